// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus.
// The fetch unit is the master; the memory is the slave.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request, redirect with drain
// of an in-flight response, and fetch-address error reporting.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IMEM_LIMIT = 32'h0000_6FFC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    fetch_unit_if.master mem,
    output logic [31:0]  instr_out,
    output logic [31:0]  pc_out,
    output logic         out_valid,
    output logic         exc_adel
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_VALID,
        S_DRAIN
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] hold_q;
    logic [31:0] hold_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic [31:0] pco_q;
    logic [31:0] pco_d;
    logic        ov_q;
    logic        ov_d;
    logic        exc_q;
    logic        exc_d;
    logic        pc_bad;

    assign pc_bad = (pc_q[1:0] != 2'b00)
                 || (pc_q < IMEM_BASE)
                 || (pc_q > IMEM_LIMIT);

    assign instr_out = instr_q;
    assign pc_out    = pco_q;
    assign out_valid = ov_q;
    assign exc_adel  = exc_q;

    // Next-state, next-output and memory request decode.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        instr_d       = instr_q;
        pco_d         = pco_q;
        ov_d          = ov_q;
        exc_d         = exc_q;
        mem.imem_req  = 1'b0;
        mem.imem_addr = pc_q;

        unique case (state_q)
            S_FETCH: begin
                if (pc_bad) begin
                    if (redirect) begin
                        pc_d    = redirect_pc;
                        instr_d = 32'h0;
                        ov_d    = 1'b0;
                        exc_d   = 1'b0;
                    end else begin
                        state_d = S_VALID;
                        instr_d = 32'h0;
                        pco_d   = pc_q;
                        ov_d    = 1'b1;
                        exc_d   = 1'b1;
                    end
                end else begin
                    mem.imem_req = 1'b1;
                    if (redirect) begin
                        pc_d    = redirect_pc;
                        instr_d = 32'h0;
                        ov_d    = 1'b0;
                        exc_d   = 1'b0;
                        if (!mem.imem_ready) begin
                            state_d = S_DRAIN;
                            hold_d  = pc_q;
                        end
                    end else if (mem.imem_ready) begin
                        state_d = S_VALID;
                        instr_d = mem.imem_rdata;
                        pco_d   = pc_q;
                        ov_d    = 1'b1;
                        exc_d   = 1'b0;
                    end
                end
            end
            S_VALID: begin
                if (redirect) begin
                    state_d = S_FETCH;
                    pc_d    = redirect_pc;
                    instr_d = 32'h0;
                    ov_d    = 1'b0;
                    exc_d   = 1'b0;
                end else if (!stall) begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + 32'd4;
                    instr_d = 32'h0;
                    ov_d    = 1'b0;
                    exc_d   = 1'b0;
                end
            end
            S_DRAIN: begin
                mem.imem_req  = 1'b1;
                mem.imem_addr = hold_q;
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (mem.imem_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            hold_q  <= 32'h0;
            instr_q <= 32'h0;
            pco_q   <= 32'h0;
            ov_q    <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            pco_q   <= pco_d;
            ov_q    <= ov_d;
            exc_q   <= exc_d;
        end
    end

endmodule
